// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared widths, owner/state encodings and the fetch word-select
//            helper for the unified memory port arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int INST_W = 32;
  localparam int DATA_W = 64;

  // Which pipeline stage owns the outstanding transaction.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Arbiter transaction phase.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // A doubleword response carries two instructions; byte-address bit 2
  // picks the upper or lower word.
  function automatic logic [INST_W-1:0] fetch_word(
    input logic [DATA_W-1:0] dword,
    input logic              hi_sel
  );
    fetch_word = hi_sel ? dword[63:32] : dword[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_prio.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_prio
// Purpose  : Combinational fetch/data priority selector with a saturating
//            data-grant streak counter that forces a waiting fetch ahead
//            after MAX_DM_STREAK consecutive data grants.
// Ports    : clk, rst_n       - clock, async active-low reset
//            arb_en           - arbitration allowed this cycle (parent idle)
//            if_req, if_flush - fetch request and redirect kill
//            dm_req           - data request
//            grant_if         - fetch wins this cycle
//            grant_dm         - data wins this cycle
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_prio #(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic if_flush,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] c_max_streak = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic                w_dm_allowed;
  logic                w_streak_full;

  assign w_streak_full = (r_streak >= c_max_streak);

  // Data has priority unless a fetch has already been passed over too often.
  assign w_dm_allowed = !if_req || !w_streak_full;
  assign grant_dm     = arb_en && dm_req && w_dm_allowed;

  // A flushed fetch is stale, so it must not be granted even if data is idle.
  assign grant_if     = arb_en && !grant_dm && if_req && !if_flush;

  // The streak only counts data grants that actually made a fetch wait; any
  // arbitration cycle without a fetch pending starts the count over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (arb_en) begin
      if (grant_if || !if_req) begin
        r_streak <= '0;
      end else if (grant_dm && !w_streak_full) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between instruction fetch (IF,
//            read-only) and the data stage (MEM, ld/sd). Keeps a single
//            transaction outstanding and routes the response to its owner.
// Ports    : clk, rst_n                        - clock, async active-low reset
//            if_req/if_addr/if_flush           - fetch request side
//            if_gnt/if_rvalid/if_rdata         - fetch grant and response
//            dm_req/dm_we/dm_addr/dm_wdata     - data request side
//            dm_gnt/dm_rvalid/dm_rdata         - data grant and response
//            mem_req/mem_we/mem_addr/mem_wdata - memory request (held to ready)
//            mem_ready/mem_rvalid/mem_rdata    - memory handshake and response
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [INST_W-1:0] if_rdata,
  // data side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              r_state;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_drop;
  logic                r_mem_req;
  logic                r_if_rvalid;
  logic                r_dm_rvalid;
  logic [INST_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_arb_en;
  logic                w_grant_if;
  logic                w_grant_dm;
  logic                w_if_kill;

  // Grants are combinational from the requests, so they are also masked by
  // reset to keep every output low while rst_n is asserted.
  assign w_arb_en = rst_n && (r_state == IDLE);

  mem_port_prio #(
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (w_arb_en),
    .if_req   (if_req),
    .if_flush (if_flush),
    .dm_req   (dm_req),
    .grant_if (w_grant_if),
    .grant_dm (w_grant_dm)
  );

  // A redirect only matters while the outstanding transaction is a fetch.
  assign w_if_kill = if_flush && (r_owner == OWN_IF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_drop      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      // Response valids are single-cycle pulses.
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_owner   <= OWN_DM;
            r_addr    <= dm_addr;
            r_we      <= dm_we;
            r_wdata   <= dm_wdata;
            r_drop    <= 1'b0;
            r_mem_req <= 1'b1;
            r_state   <= ISSUE;
          end else if (w_grant_if) begin
            r_owner   <= OWN_IF;
            r_addr    <= if_addr;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_drop    <= 1'b0;
            r_mem_req <= 1'b1;
            r_state   <= ISSUE;
          end
        end

        ISSUE: begin
          if (w_if_kill) begin
            r_drop <= 1'b1;
          end
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT;
          end
        end

        WAIT: begin
          if (w_if_kill) begin
            r_drop <= 1'b1;
          end
          if (mem_rvalid) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            if (r_owner == OWN_DM) begin
              // A store acknowledge returns zero data.
              r_dm_rvalid <= 1'b1;
              r_dm_rdata  <= r_we ? '0 : mem_rdata;
            end else if (!(r_drop || if_flush)) begin
              // Dropped fetches are consumed silently and leave the last
              // delivered instruction on if_rdata.
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= fetch_word(mem_rdata, r_addr[2]);
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = w_grant_if;
  assign dm_gnt    = w_grant_dm;

  // A redirect arriving with the registered pulse still kills it.
  assign if_rvalid = r_if_rvalid && !if_flush;
  assign if_rdata  = r_if_rdata;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: arbitration vector
//            table, directed multi-cycle sequences and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W        = 64;
  localparam int MAX_DM_STREAK = 4;
  localparam int RND_CYCLES    = 1500;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_flush;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [INST_W-1:0] if_rdata;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W        (ADDR_W),
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  // Grant, then accept on the first issue cycle; returns at the WAIT cycle.
  task automatic start_txn(input bit is_dm, input bit we, input logic [63:0] a,
                           input logic [63:0] wd);
    if (is_dm) begin
      dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    smp();
    chk(is_dm ? "txn_dm_gnt" : "txn_if_gnt", is_dm ? dm_gnt : if_gnt, 1);
    cyc();
    if_req = 0; dm_req = 0; mem_ready = 1;
    smp();
    chk("txn_mem_req", mem_req, 1);
    chk("txn_mem_addr", mem_addr, a);
    cyc();
    mem_ready = 0;
  endtask

  task automatic fetch_sel(input logic [63:0] a, input logic [63:0] d, input logic [31:0] e);
    start_txn(0, 0, a, 0);
    mem_rvalid = 1; mem_rdata = d;
    smp();
    cyc();
    mem_rvalid = 0; mem_rdata = '0;
    smp();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_word", if_rdata, e);
    cyc();
  endtask

  typedef struct {
    logic ir, fl, dr, dwe;
    logic eig, edg;
  } vec_t;
  vec_t vt[8];

  // Reference model: one outstanding transaction described by its phase flags.
  bit          m_busy, m_issue, m_wait, m_drop, m_own_dm, m_we;
  logic [63:0] m_addr, m_wdata;
  int          m_streak;
  bit          m_if_rv, m_dm_rv;
  logic [31:0] m_if_data;
  logic [63:0] m_dm_data;
  bit          if_pend, dm_pend, e_dm, e_if;

  initial begin
    logic [9:0]  order;
    int          ng;
    bit          acc;
    logic [63:0] bp_addr, bp_wdata;

    rst_n = 0;
    clear_inputs();

    // ---------------- reset state with requests pending ----------------
    if_req = 1; dm_req = 1; if_addr = 64'h40; dm_addr = 64'h80; mem_rvalid = 1;
    smp();
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);

    // ---------------- arbitration vector table (streak at 0) ----------------
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if_req = vt[i].ir; if_flush = vt[i].fl; dm_req = vt[i].dr; dm_we = vt[i].dwe;
      if_addr = 64'h1000 + 64'(i) * 8; dm_addr = 64'h2000 + 64'(i) * 8;
      dm_wdata = 64'h5555_0000_0000_0000 + 64'(i);
      smp();
      chk("vec_if_gnt", if_gnt, vt[i].eig);
      chk("vec_dm_gnt", dm_gnt, vt[i].edg);
      cyc();
      if_req = 0; dm_req = 0; if_flush = 0;
      smp();
      chk("vec_mem_req", mem_req, vt[i].eig | vt[i].edg);
      chk("vec_mem_we", mem_we, vt[i].edg & vt[i].dwe);
      if (vt[i].eig | vt[i].edg)
        chk("vec_mem_addr", mem_addr, vt[i].edg ? dm_addr : if_addr);
    end

    // ---------------- single load, minimum latency ----------------
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 64'h100;
    smp();
    chk("ld_gnt_c0", dm_gnt, 1);
    chk("ld_mem_req_c0", mem_req, 0);
    cyc();
    dm_req = 0; mem_ready = 1;
    smp();
    chk("ld_mem_req_c1", mem_req, 1);
    chk("ld_mem_addr_c1", mem_addr, 64'h100);
    chk("ld_mem_we_c1", mem_we, 0);
    cyc();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    smp();
    chk("ld_mem_req_c2", mem_req, 0);
    chk("ld_rvalid_c2", dm_rvalid, 0);
    cyc();
    mem_rvalid = 0; mem_rdata = '0;
    smp();
    chk("ld_rvalid_c3", dm_rvalid, 1);
    chk("ld_rdata_c3", dm_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("ld_if_rvalid_c3", if_rvalid, 0);
    cyc();
    smp();
    chk("ld_rvalid_c4", dm_rvalid, 0);
    chk("ld_rdata_hold", dm_rdata, 64'hDEADBEEF_CAFEF00D);

    // ---------------- fetch word select ----------------
    do_reset();
    fetch_sel(64'h104, 64'h11111111_22222222, 32'h11111111);
    fetch_sel(64'h100, 64'h11111111_22222222, 32'h22222222);

    // ---------------- backpressure on a store ----------------
    do_reset();
    bp_addr = 64'h200; bp_wdata = 64'hA5A5_5A5A_0123_4567;
    dm_req = 1; dm_we = 1; dm_addr = bp_addr; dm_wdata = bp_wdata;
    smp();
    chk("bp_gnt", dm_gnt, 1);
    cyc();
    dm_addr = 64'h999; dm_wdata = '1; dm_we = 0; if_req = 1; if_addr = 64'h700;
    for (int c = 1; c <= 6; c++) begin
      mem_ready = (c == 6);
      smp();
      chk("bp_mem_req", mem_req, 1);
      chk("bp_mem_addr", mem_addr, bp_addr);
      chk("bp_mem_wdata", mem_wdata, bp_wdata);
      chk("bp_mem_we", mem_we, 1);
      chk("bp_no_dm_gnt", dm_gnt, 0);
      chk("bp_no_if_gnt", if_gnt, 0);
      cyc();
    end
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    smp();
    chk("bp_mem_req_drop", mem_req, 0);
    cyc();
    mem_rvalid = 0;
    smp();
    chk("bp_st_ack", dm_rvalid, 1);
    chk("bp_st_rdata", dm_rdata, 0);
    chk("bp_rearb_dm", dm_gnt, 1);
    cyc();

    // ---------------- starvation guard ----------------
    do_reset();
    if_req = 1; dm_req = 1; if_addr = 64'h800; dm_addr = 64'h900; mem_ready = 1;
    order = '0; ng = 0; acc = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      mem_rvalid = acc; mem_rdata = 64'(c);
      smp();
      if (if_gnt && dm_gnt) chk("starve_excl", 2'b11, 2'b01);
      if (if_gnt) begin order[ng] = 1'b1; ng++; end
      else if (dm_gnt) ng++;
      acc = mem_req && mem_ready;
      cyc();
    end
    chk("starve_count", 64'(ng), 10);
    chk("starve_order", order, 10'b1000010000);

    // ---------------- flush while fetch is in WAIT ----------------
    do_reset();
    start_txn(0, 0, 64'h300, 0);
    if_flush = 1;
    smp();
    chk("fl_rvalid_wait", if_rvalid, 0);
    cyc();
    if_flush = 0; mem_rvalid = 1; mem_rdata = 64'h3333_4444_5555_6666;
    dm_req = 1; dm_we = 0; dm_addr = 64'h600;
    smp();
    chk("fl_no_early_gnt", dm_gnt, 0);
    cyc();
    mem_rvalid = 0;
    smp();
    chk("fl_if_rvalid", if_rvalid, 0);
    chk("fl_if_rdata", if_rdata, 0);
    chk("fl_next_dm_gnt", dm_gnt, 1);
    cyc();
    dm_req = 0;

    // ---------------- flush coinciding with the response pulse ----------------
    do_reset();
    start_txn(0, 0, 64'h308, 0);
    mem_rvalid = 1; mem_rdata = 64'h7777_8888_9999_AAAA;
    smp();
    cyc();
    mem_rvalid = 0; if_flush = 1;
    smp();
    chk("fl2_pulse_killed", if_rvalid, 0);
    cyc();
    if_flush = 0;
    smp();
    chk("fl2_no_late_pulse", if_rvalid, 0);

    // ---------------- reset during WAIT ----------------
    do_reset();
    start_txn(1, 0, 64'h400, 0);
    mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    smp();
    cyc();
    mem_rvalid = 0;
    smp();
    chk("rw_pre_rdata", dm_rdata, 64'h1234_5678_9ABC_DEF0);
    cyc();
    start_txn(1, 0, 64'h408, 0);
    rst_n = 0; dm_req = 1; dm_addr = 64'h410;
    smp();
    chk("rw_dm_gnt", dm_gnt, 0);
    chk("rw_mem_req", mem_req, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_dm_rdata", dm_rdata, 0);
    chk("rw_dm_rvalid", dm_rvalid, 0);
    cyc();
    rst_n = 1; dm_req = 0; mem_rvalid = 1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    smp();
    chk("rw_idle_mem_req", mem_req, 0);
    cyc();
    mem_rvalid = 0;
    smp();
    chk("rw_no_rvalid", dm_rvalid, 0);
    chk("rw_rdata_zero", dm_rdata, 0);
    cyc();
    dm_req = 1; dm_addr = 64'h500;
    smp();
    chk("rw_idle_gnt", dm_gnt, 1);
    cyc();

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    m_busy = 0; m_issue = 0; m_wait = 0; m_drop = 0; m_own_dm = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_streak = 0;
    m_if_rv = 0; m_dm_rv = 0; m_if_data = '0; m_dm_data = '0;
    if_pend = 0; dm_pend = 0;
    for (int c = 0; c < RND_CYCLES; c++) begin
      if (!if_pend && $urandom_range(1, 0) == 1) begin
        if_pend = 1; if_addr = {$urandom, $urandom} & ~64'h3;
      end else if (if_pend && $urandom_range(15, 0) == 0) begin
        if_pend = 0;
      end
      if (!dm_pend && $urandom_range(1, 0) == 1) begin
        dm_pend = 1; dm_we = 1'($urandom_range(1, 0));
        dm_addr = {$urandom, $urandom} & ~64'h7; dm_wdata = {$urandom, $urandom};
      end else if (dm_pend && $urandom_range(15, 0) == 0) begin
        dm_pend = 0;
      end
      if_req = if_pend; dm_req = dm_pend;
      if_flush   = ($urandom_range(7, 0) == 0);
      mem_ready  = 1'($urandom_range(1, 0));
      mem_rvalid = m_wait ? ($urandom_range(2, 0) == 0) : (!m_busy && $urandom_range(15, 0) == 0);
      mem_rdata  = {$urandom, $urandom};

      e_dm = !m_busy && dm_req && (!if_req || m_streak < MAX_DM_STREAK);
      e_if = !m_busy && !e_dm && if_req && !if_flush;

      smp();
      chk("rnd_dm_gnt", dm_gnt, e_dm);
      chk("rnd_if_gnt", if_gnt, e_if);
      chk("rnd_mem_req", mem_req, m_issue);
      if (m_issue) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", mem_we, m_we);
        if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_if_rvalid", if_rvalid, m_if_rv && !if_flush);
      chk("rnd_dm_rvalid", dm_rvalid, m_dm_rv);
      chk("rnd_if_rdata", if_rdata, m_if_data);
      chk("rnd_dm_rdata", dm_rdata, m_dm_data);

      m_if_rv = 0; m_dm_rv = 0;
      if (!m_busy) begin
        if (e_if || !if_req) m_streak = 0;
        else if (e_dm && m_streak < MAX_DM_STREAK) m_streak++;
        if (e_dm || e_if) begin
          m_busy = 1; m_issue = 1; m_wait = 0; m_drop = 0; m_own_dm = e_dm;
          m_addr = e_dm ? dm_addr : if_addr;
          m_we = e_dm && dm_we;
          m_wdata = dm_wdata;
        end
      end else begin
        if (!m_own_dm && if_flush) m_drop = 1;
        if (m_issue) begin
          if (mem_ready) begin m_issue = 0; m_wait = 1; end
        end else if (m_wait && mem_rvalid) begin
          m_busy = 0; m_wait = 0;
          if (m_own_dm) begin
            m_dm_rv = 1; m_dm_data = m_we ? 64'h0 : mem_rdata;
          end else if (!m_drop) begin
            m_if_rv = 1; m_if_data = m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end
      end
      if (e_if) if_pend = 0;
      if (e_dm) dm_pend = 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (ld/sd).
- Arbitrates, holds one transaction outstanding at a time, and routes the response back to its owner.
- Drives per-side grant and response-valid; pipeline stall logic derives stalls from these.

Parameters:
ADDR_W, 64, byte-address width for both requesters and the memory.
MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits before fetch is forced ahead.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
if_req  in  1  fetch request; held until if_gnt.
if_addr  in  ADDR_W  fetch byte address; bits [1:0] are zero.
if_flush  in  1  kill the in-flight or requesting fetch (branch/jump redirect).
if_gnt  out  1  one-cycle pulse: fetch accepted.
if_rvalid  out  1  one-cycle pulse: if_rdata valid.
if_rdata  out  INST_W  fetched instruction.
dm_req  in  1  data request; held until dm_gnt.
dm_we  in  1  1 = store (sd), 0 = load (ld).
dm_addr  in  ADDR_W  data byte address, doubleword aligned.
dm_wdata  in  DATA_W  store data.
dm_gnt  out  1  one-cycle pulse: data request accepted.
dm_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
dm_rdata  out  DATA_W  load data; 0 for a store acknowledge.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_ready  in  1  memory accepts the request this cycle.
mem_rvalid  in  1  response or write acknowledge, exactly one per accepted request.
mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_req, gnt, rvalid and rdata. Streak counter 0, owner and drop flag cleared. A reset mid-transaction abandons the transaction; a mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - If dm_req and (!if_req or streak < MAX_DM_STREAK): grant data.
  - Else if if_req and !if_flush: grant fetch.
  - Else: no grant.
  - On a grant: pulse the corresponding gnt in the same cycle (combinational from req), capture address/we/wdata/owner into registers, go to ISSUE.
- Streak counter:
  - Increments on a data grant made while if_req is high, saturating at MAX_DM_STREAK.
  - Clears on a fetch grant, and on any arbitration cycle where if_req is low.
- ISSUE: mem_req=1 with the captured fields, held stable until mem_ready; then go to WAIT. mem_req falls the cycle after mem_ready.
- WAIT: on mem_rvalid, register the response and return to IDLE. The owner's rvalid pulses in the next cycle, and arbitration is permitted in that same cycle.
- Fetch data select: if_rdata = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- Store: dm_rvalid pulses on the acknowledge with dm_rdata = 0.
- rdata outputs hold their value between pulses.
- Minimum latency: request in cycle 0 (gnt), mem_req in cycle 1, mem_ready in 1, mem_rvalid in 2, owner rvalid in 3.
- Fetch flush:
  - if_flush while the owner is IF in ISSUE or WAIT sets the drop flag. The transaction still completes on the memory side, but if_rvalid is suppressed.
  - A flush in the same cycle as the registered response output also suppresses that pulse.
  - A flush in IDLE blocks the fetch grant that cycle.
  - if_flush never affects data transactions.
- Simultaneous requests: both requests with streak below limit grants data; the fetch waits.
- A requester deasserting req without a grant is legal; nothing is captured.

Decomposition:
- Shared definitions (def.h / shared package):
  - owner enum (OWN_IF, OWN_DM);
  - state enum (IDLE, ISSUE, WAIT);
  - existing INST_W and DATA_W widths.
- Natural sub-module: mem_port_prio, the combinational priority selector plus saturating streak counter. It outputs grant_if and grant_dm. The parent holds the FSM and datapath registers.

Test Plan:
- Single load: dm_req, dm_addr=0x100, mem_ready at cycle 1, mem_rvalid at 2 with 0xDEADBEEF_CAFEF00D -> dm_gnt at 0, mem_req only in cycle 1, dm_rvalid at 3 with that data.
- Fetch word select: if_addr=0x104, mem_rdata=0x11111111_22222222 -> if_rdata=0x11111111. With if_addr=0x100 -> if_rdata=0x22222222.
- Backpressure: mem_ready low for 5 cycles -> mem_req, mem_addr and mem_wdata stable for all 6 cycles. No second grant occurs.
- Starvation guard: if_req and dm_req held high continuously -> grant order D,D,D,D,I,D,D,D,D,I. Streak returns to 0 after each fetch grant.
- Flush in flight: fetch granted, if_flush pulse during WAIT -> mem_rvalid consumed, if_rvalid stays 0. The next dm_req is granted in the cycle after the response.
- Reset mid-WAIT: rst_n low for 1 cycle, then mem_rvalid -> all outputs 0 immediately, no rvalid pulse, state IDLE.
